// File: rtl/stream_word_packer.sv
// Packs RATIO consecutive FIFO entries into one little-endian output word on a
// valid/ready stream, with a flush request that emits a partially filled word.
module stream_word_packer #(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int OUT_WIDTH = IN_WIDTH * RATIO,
    parameter int CNT_WIDTH = $clog2(RATIO) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_pop_valid,
    input  logic [IN_WIDTH-1:0]  i_pop_data,
    output logic                 o_pop_ready,
    input  logic                 i_flush,
    output logic                 o_word_valid,
    output logic [OUT_WIDTH-1:0] o_word_data,
    output logic [CNT_WIDTH-1:0] o_word_count,
    input  logic                 i_word_ready
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(RATIO - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(RATIO);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t                 state_r, state_s;
    logic [CNT_WIDTH-1:0]   k_r, k_s;
    logic                   flush_pend_r, flush_pend_s;
    logic [OUT_WIDTH-1:0]   word_r, word_s;
    logic [CNT_WIDTH-1:0]   count_r, count_s;
    logic                   pop_ready_s;
    logic                   take_s;
    logic [CNT_WIDTH-1:0]   filled_s;

    // Ready is gated by reset so nothing is consumed while the block is held in reset.
    assign pop_ready_s  = !i_rst && ((state_r == FILL) || i_word_ready);
    assign take_s       = i_pop_valid && pop_ready_s;
    assign filled_s     = k_r + CNT_WIDTH'(take_s);

    assign o_pop_ready  = pop_ready_s;
    assign o_word_valid = (state_r == HOLD);
    assign o_word_data  = word_r;
    assign o_word_count = count_r;

    // Next-state, lane write and flush handling.
    always_comb begin
        state_s      = state_r;
        k_s          = k_r;
        flush_pend_s = flush_pend_r;
        word_s       = word_r;
        count_s      = count_r;
        case (state_r)
            FILL: begin
                for (int l = 0; l < RATIO; l++) begin
                    if (take_s && (k_r == CNT_WIDTH'(l))) begin
                        word_s[l*IN_WIDTH +: IN_WIDTH] = i_pop_data;
                    end else begin
                        word_s[l*IN_WIDTH +: IN_WIDTH] = word_r[l*IN_WIDTH +: IN_WIDTH];
                    end
                end
                if (take_s && (k_r == LAST_LANE)) begin
                    state_s      = HOLD;
                    count_s      = FULL_CNT;
                    k_s          = CNT_ZERO;
                    flush_pend_s = 1'b0;
                end else if (flush_pend_r || i_flush) begin
                    // A flush with nothing buffered is simply dropped.
                    flush_pend_s = 1'b0;
                    if (filled_s != CNT_ZERO) begin
                        state_s = HOLD;
                        count_s = filled_s;
                        k_s     = CNT_ZERO;
                    end else begin
                        k_s     = filled_s;
                    end
                end else begin
                    k_s = filled_s;
                end
            end
            HOLD: begin
                flush_pend_s = flush_pend_r || i_flush;
                if (i_word_ready) begin
                    state_s = FILL;
                    count_s = CNT_ZERO;
                    word_s  = {OUT_WIDTH{1'b0}};
                    // The entry taken on the accepting edge starts the next word.
                    if (take_s) begin
                        word_s[IN_WIDTH-1:0] = i_pop_data;
                        k_s                  = CNT_ONE;
                    end else begin
                        k_s                  = CNT_ZERO;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s      = FILL;
                k_s          = CNT_ZERO;
                flush_pend_s = 1'b0;
                word_s       = {OUT_WIDTH{1'b0}};
                count_s      = CNT_ZERO;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= FILL;
            k_r          <= CNT_ZERO;
            flush_pend_r <= 1'b0;
            word_r       <= {OUT_WIDTH{1'b0}};
            count_r      <= CNT_ZERO;
        end else begin
            state_r      <= state_s;
            k_r          <= k_s;
            flush_pend_r <= flush_pend_s;
            word_r       <= word_s;
            count_r      <= count_s;
        end
    end

endmodule

// File: tb/tb_stream_word_packer.sv
// Self-checking bench for stream_word_packer: directed scenarios plus random
// traffic, compared each cycle against a queue-based reference model.
module tb_stream_word_packer;

    localparam int IW = 8;
    localparam int R  = 4;
    localparam int OW = IW * R;
    localparam int CW = $clog2(R) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pv;
    logic [IW-1:0] pd;
    logic          pr;
    logic          fl;
    logic          wv;
    logic [OW-1:0] wd;
    logic [CW-1:0] wc;
    logic          wr;

    stream_word_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pop_valid  (pv),
        .i_pop_data   (pd),
        .o_pop_ready  (pr),
        .i_flush      (fl),
        .o_word_valid (wv),
        .o_word_data  (wd),
        .o_word_count (wc),
        .i_word_ready (wr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the FIFO contents, the entries gathered for the next
    // word, the word on offer (if any) and a remembered flush request.
    logic [7:0]  fifo_q[$];
    logic [7:0]  cur_q[$];
    bit          held;
    logic [31:0] held_data;
    int          held_cnt;
    bit          pend;
    logic [31:0] acc_d[$];
    int          acc_c[$];
    logic [31:0] ex_d[$];
    int          ex_c[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fifo_q.delete();
        cur_q.delete();
        held      = 1'b0;
        pend      = 1'b0;
        held_data = 32'h0;
        held_cnt  = 0;
    endtask

    task automatic emit();
        held      = 1'b1;
        held_data = 32'h0;
        foreach (cur_q[i]) held_data = held_data | (32'(cur_q[i]) << (8 * i));
        held_cnt  = cur_q.size();
        cur_q.delete();
        pend      = 1'b0;
    endtask

    task automatic cyc(input bit f, input bit w);
        bit         exp_ready;
        bit         take;
        logic [7:0] d;
        pv = (fifo_q.size() > 0);
        d  = pv ? fifo_q[0] : 8'h00;
        pd = d;
        fl = f;
        wr = w;
        #3;
        exp_ready = !held || w;
        chk("pop_ready", 32'(pr), 32'(exp_ready));
        chk("word_valid", 32'(wv), 32'(held));
        if (held) begin
            chk("word_data", wd, held_data);
            chk("word_count", 32'(wc), 32'(held_cnt));
        end
        if (wv && w) begin
            acc_d.push_back(wd);
            acc_c.push_back(int'(wc));
        end
        take = pv && exp_ready;
        @(posedge clk);
        if (held) begin
            pend = pend || f;
            if (w) begin
                held = 1'b0;
                cur_q.delete();
                if (take) cur_q.push_back(d);
            end
        end else begin
            if (take) cur_q.push_back(d);
            if (cur_q.size() == R) begin
                emit();
            end else if (pend || f) begin
                if (cur_q.size() > 0) emit();
                else pend = 1'b0;
            end
        end
        if (take) void'(fifo_q.pop_front());
        #1;
        fl = 1'b0;
    endtask

    task automatic run(input int n, input bit w);
        for (int i = 0; i < n; i++) cyc(1'b0, w);
    endtask

    task automatic expect_word(input logic [31:0] d, input int c);
        ex_d.push_back(d);
        ex_c.push_back(c);
    endtask

    task automatic check_acc(input string tag);
        chk({tag, "_nwords"}, 32'(acc_d.size()), 32'(ex_d.size()));
        for (int i = 0; i < ex_d.size() && i < acc_d.size(); i++) begin
            chk({tag, "_data"}, acc_d[i], ex_d[i]);
            chk({tag, "_count"}, 32'(acc_c[i]), 32'(ex_c[i]));
        end
        acc_d.delete();
        acc_c.delete();
        ex_d.delete();
        ex_c.delete();
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_valid"}, 32'(wv), 32'h0);
        chk({tag, "_data"}, wd, 32'h0);
        chk({tag, "_count"}, 32'(wc), 32'h0);
        chk({tag, "_ready"}, 32'(pr), 32'h0);
        model_reset();
        pv = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pv  = 1'b0;
        pd  = 8'h00;
        fl  = 1'b0;
        wr  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("reset");

        // Single full word.
        fifo_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run(6, 1'b1);
        expect_word(32'hD4C3B2A1, 4);
        check_acc("t1");

        // Backpressure, same-edge refill, then flush of a partial word.
        fifo_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        run(4, 1'b0);
        run(5, 1'b0);
        chk("t2_e5_waiting", 32'(fifo_q.size()), 32'd1);
        cyc(1'b0, 1'b1);
        fifo_q.push_back(8'hF6);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        expect_word(32'hD4C3B2A1, 4);
        expect_word(32'h0000F6E5, 2);
        check_acc("t23");

        // Flush with nothing buffered is dropped.
        cyc(1'b1, 1'b1);
        run(2, 1'b1);
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run(6, 1'b1);
        expect_word(32'h04030201, 4);
        check_acc("t4");

        // Sustained streaming.
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
        run(18, 1'b1);
        expect_word(32'h03020100, 4);
        expect_word(32'h07060504, 4);
        expect_word(32'h0B0A0908, 4);
        expect_word(32'h0F0E0D0C, 4);
        check_acc("t5");

        // Reset mid-word and during HOLD.
        fifo_q = '{8'h55, 8'h66};
        run(2, 1'b1);
        do_reset("rst_mid");
        fifo_q = '{8'h71, 8'h72, 8'h73, 8'h74};
        run(6, 1'b0);
        do_reset("rst_hold");
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run(6, 1'b1);
        expect_word(32'h44332211, 4);
        check_acc("t6");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0) fifo_q.push_back(8'($urandom));
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1);
        chk("rand_drained", 32'(fifo_q.size()), 32'd0);
        acc_d.delete();
        acc_c.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
